mem_access_unit: RTL and testbench

- CPU-side initiator for the word-organised data memory in the MEM stage.
- Accepts one load/store per request and converts byte/half accesses into word-aligned memory transactions: extract plus sign/zero-extend for loads, read-modify-write for sub-word stores.
- Drives a req/ack handshake toward memory and stalls the pipeline until the access completes, faults, or is rejected as misaligned.

---
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: word/half/byte loads and stores over a req/ack word bus.
// Optional macro MEM_TRACE_EN prints one trace line per completed memory write.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_extend,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] debug_pc,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  output logic        cpu_misaligned,
  output logic        cpu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, stateNext;
  logic        writeL, extendL;
  logic [1:0]  widthL, laneL;
  logic [15:0] wdataL;
  logic        memReq, misFlag, faultFlag;
  logic [15:0] wdCount;
  logic [31:0] rdataReg, memAddrReg, memWdataReg;
  logic        reqMisaligned, handshake, timeout;

  function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [1:0] width,
                                              input logic [1:0] lane, input logic extend);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sExt;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (width)
      2'b10: begin
        sExt = b;
        r = extend ? sExt : {24'b0, b};
      end
      2'b01: begin
        sExt = h;
        r = extend ? sExt : {16'b0, h};
      end
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] storeMerge(input logic [31:0] word, input logic [1:0] width,
                                             input logic [1:0] lane, input logic [15:0] data);
    logic [31:0] r;
    r = word;
    if (width == 2'b10) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = data;
    end else begin
      r[15:0] = data;
    end
    return r;
  endfunction

  assign reqMisaligned = (cpu_width == 2'b11) ||
                         (cpu_width == 2'b01 && cpu_addr[0]) ||
                         (cpu_width == 2'b00 && cpu_addr[1:0] != 2'b00);
  assign handshake = memReq && mem_ack;
  // Abort on the edge where the stall count would reach ACK_TIMEOUT.
  assign timeout   = (ACK_TIMEOUT != 0) && memReq && !mem_ack &&
                     (wdCount == 16'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (cpu_req) begin
        if (reqMisaligned)                stateNext = DONE;
        else if (cpu_write && cpu_width == 2'b00) stateNext = WR;
        else                              stateNext = RD;
      end
      RD:   if (handshake)    stateNext = writeL ? WR : DONE;
            else if (timeout) stateNext = DONE;
      WR:   if (handshake || timeout) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Operand capture at accept; held until the access finishes.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) begin
      writeL  <= cpu_write;
      widthL  <= cpu_width;
      extendL <= cpu_extend;
      laneL   <= cpu_addr[1:0];
      wdataL  <= cpu_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memReq      <= 1'b0;
      wdCount     <= 16'd0;
      misFlag     <= 1'b0;
      faultFlag   <= 1'b0;
      rdataReg    <= 32'd0;
      memAddrReg  <= 32'd0;
      memWdataReg <= 32'd0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          memAddrReg  <= {cpu_addr[31:2], 2'b00};
          memWdataReg <= cpu_wdata;
          misFlag     <= reqMisaligned;
          faultFlag   <= 1'b0;
          wdCount     <= 16'd0;
          if (reqMisaligned) rdataReg <= 32'd0;
          else               memReq   <= 1'b1;
        end
        RD, WR: begin
          if (handshake) begin
            memReq <= 1'b0;
            if (state == RD) begin
              if (writeL) begin
                memWdataReg <= storeMerge(mem_rdata, widthL, laneL, wdataL);
                wdCount     <= 16'd0;
              end else begin
                rdataReg <= loadExtract(mem_rdata, widthL, laneL, extendL);
              end
            end
          end else if (timeout) begin
            memReq    <= 1'b0;
            faultFlag <= 1'b1;
            rdataReg  <= 32'd0;
          end else if (memReq) begin
            wdCount <= wdCount + 16'd1;
          end else begin
            // Idle gap between read and write phases of a read-modify-write.
            memReq  <= 1'b1;
            wdCount <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_done       = (state == DONE);
  assign cpu_misaligned = cpu_done && misFlag;
  assign cpu_fault      = cpu_done && faultFlag;
  assign cpu_stall      = cpu_req && !cpu_done;
  assign cpu_rdata      = rdataReg;
  assign mem_req        = memReq;
  assign mem_we         = (state == WR);
  assign mem_addr       = memAddrReg;
  assign mem_wdata      = memWdataReg;

`ifdef MEM_TRACE_EN
  logic [31:0] pcL;
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) pcL <= debug_pc;
    if (!reset && state == WR && handshake)
      $display("%d@%h: *%h <= %h", $time, pcL, {memAddrReg[31:2], laneL}, memWdataReg);
  end
`else
  logic unusedPc;
  assign unusedPc = ^debug_pc;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model predicting the cycle timeline,
// a responder memory with random wait states, directed literal cases and a random run.
module tb_mem_access_unit;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write, cpu_extend;
  logic [1:0]  cpu_width;
  logic [31:0] cpu_addr, cpu_wdata, debug_pc;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_stall, cpu_misaligned, cpu_fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_width(cpu_width), .cpu_extend(cpu_extend), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .debug_pc(debug_pc), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall), .cpu_misaligned(cpu_misaligned),
    .cpu_fault(cpu_fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    bit req; bit we; logic [31:0] addr; logic [31:0] wdata;
    bit done; bit mis; bit fault; bit chk; logic [31:0] rdata;
  } exp_t;

  exp_t        expQ[$];
  exp_t        cmpE;
  logic [31:0] memArr [0:15];
  int          checks = 0, errors = 0;
  bit          checkEn = 0, noAck = 0, inDoneCycle = 0;
  int          rdDelay = 0, wrDelay = 0, waitCnt = 0;
  logic [31:0] rA, rW;
  logic [1:0]  rWidth;
  int          rSel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit req, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit done, input bit mis,
                              input bit fault, input bit chk, input logic [31:0] rd);
    exp_t e;
    e.req = req; e.we = we; e.addr = addr; e.wdata = wdata;
    e.done = done; e.mis = mis; e.fault = fault; e.chk = chk; e.rdata = rd;
    return e;
  endfunction

  // Reference load: shift the lane down, mask, then add the sign fill if needed.
  function automatic logic [31:0] mdlLoad(input logic [31:0] word, input logic [1:0] w,
                                          input logic [1:0] off, input bit ext);
    logic [31:0] v;
    if (w == 2'b10) begin
      v = (word >> (8 * int'(off))) & 32'hFF;
      if (ext && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'b01) begin
      v = (word >> (16 * int'(off[1]))) & 32'hFFFF;
      if (ext && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] mdlMerge(input logic [31:0] word, input logic [1:0] w,
                                           input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    mask = (w == 2'b10) ? 32'hFF : 32'hFFFF;
    sh   = (w == 2'b10) ? 8 * int'(off) : 16 * int'(off[1]);
    return (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Memory responder: ack after the requested number of wait cycles, stray acks while idle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (!noAck && waitCnt >= (mem_we ? wrDelay : rdDelay)) begin
        mem_ack   = 1'b1;
        mem_rdata = memArr[mem_addr[5:2]];
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        waitCnt++;
      end
    end else begin
      waitCnt   = 0;
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  always @(posedge clk)
    if (!reset && mem_req && mem_ack && mem_we) memArr[mem_addr[5:2]] <= mem_wdata;

  always @(negedge clk) begin
    if (checkEn) begin
      cmpE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (expQ.size() > 0) cmpE = expQ.pop_front();
      check("mem_req", mem_req, cmpE.req);
      if (cmpE.req) begin
        check("mem_we", mem_we, cmpE.we);
        check("mem_addr", mem_addr, cmpE.addr);
        if (cmpE.we) check("mem_wdata", mem_wdata, cmpE.wdata);
      end
      check("cpu_done", cpu_done, cmpE.done);
      check("cpu_misaligned", cpu_misaligned, cmpE.mis);
      check("cpu_fault", cpu_fault, cpu_fault ? cmpE.fault : cmpE.fault);
      check("cpu_stall", cpu_stall, cpu_req & ~cmpE.done);
      if (cmpE.done && cmpE.chk) check("cpu_rdata", cpu_rdata, cmpE.rdata);
    end
  end

  // Called at posedge+1; returns at posedge+1 inside the cpu_done cycle.
  task automatic doReq(input bit wr, input logic [1:0] w, input bit ext, input logic [31:0] a,
                       input logic [31:0] wd, input int rdD, input int wrD, input bit na);
    logic [31:0] word, wa;
    bit mis;
    int n;
    cpu_req = 1; cpu_write = wr; cpu_width = w; cpu_extend = ext;
    cpu_addr = a; cpu_wdata = wd; debug_pc = $urandom;
    rdDelay = rdD; wrDelay = wrD; noAck = na;
    if (inDoneCycle) @(posedge clk);
    @(posedge clk);
    wa   = {a[31:2], 2'b00};
    word = memArr[a[5:2]];
    mis  = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b00 && a[1:0] != 2'b00);
    if (mis) begin
      expQ.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
      n = 0;
    end else if (na) begin
      for (int i = 0; i < TMO; i++) expQ.push_back(mk(1, wr && w == 2'b00, wa, wd, 0, 0, 0, 0, 0));
      expQ.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0));
      n = TMO;
    end else if (!wr) begin
      for (int i = 0; i <= rdD; i++) expQ.push_back(mk(1, 0, wa, 0, 0, 0, 0, 0, 0));
      expQ.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, mdlLoad(word, w, a[1:0], ext)));
      n = rdD + 1;
    end else if (w == 2'b00) begin
      for (int i = 0; i <= wrD; i++) expQ.push_back(mk(1, 1, wa, wd, 0, 0, 0, 0, 0));
      expQ.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      n = wrD + 1;
    end else begin
      for (int i = 0; i <= rdD; i++) expQ.push_back(mk(1, 0, wa, 0, 0, 0, 0, 0, 0));
      expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i <= wrD; i++)
        expQ.push_back(mk(1, 1, wa, mdlMerge(word, w, a[1:0], wd), 0, 0, 0, 0, 0));
      expQ.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      n = rdD + wrD + 3;
    end
    #1;
    cpu_write = 1'($urandom); cpu_width = 2'($urandom); cpu_extend = 1'($urandom);
    cpu_addr = $urandom; cpu_wdata = $urandom;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
    cpu_req = 0;
    inDoneCycle = 1;
  endtask

  task automatic idle(input int k);
    cpu_req = 0;
    repeat (k) @(posedge clk);
    #1;
    if (k > 0) inDoneCycle = 0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_we"}, mem_we, 32'd0);
    check({tag, "_mem_req"}, mem_req, 32'd0);
    check({tag, "_done"}, cpu_done, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) memArr[i] = $urandom;
    reset = 1; cpu_req = 0; cpu_write = 0; cpu_width = 0; cpu_extend = 0;
    cpu_addr = 0; cpu_wdata = 0; debug_pc = 0;
    repeat (3) @(posedge clk);
    #1 checkEn = 1;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 reset = 0;
    idle(1);

    memArr[4] = 32'hDEADBEEF;
    doReq(0, 2'b00, 0, 32'h10, 0, 0, 0, 0);
    check("lw_lit", cpu_rdata, 32'hDEADBEEF);
    memArr[4] = 32'h80FF7F01;
    doReq(0, 2'b10, 1, 32'h13, 0, 0, 0, 0);
    check("lb_lit", cpu_rdata, 32'hFFFFFF80);
    doReq(0, 2'b10, 0, 32'h11, 0, 0, 0, 0);
    check("lbu_lit", cpu_rdata, 32'h0000007F);
    doReq(0, 2'b01, 1, 32'h12, 0, 0, 0, 0);
    check("lh_lit", cpu_rdata, 32'hFFFF80FF);
    check("model_lb", mdlLoad(32'h80FF7F01, 2'b10, 2'd3, 1), 32'hFFFFFF80);
    check("model_merge", mdlMerge(32'h11223344, 2'b01, 2'd2, 32'h0000CAFE), 32'hCAFE3344);
    memArr[8] = 32'h11223344;
    doReq(1, 2'b10, 0, 32'h21, 32'h000000AB, 0, 0, 0);
    check("sb_mem_lit", memArr[8], 32'h1122AB44);
    memArr[8] = 32'h11223344;
    doReq(1, 2'b01, 0, 32'h22, 32'h0000CAFE, 0, 0, 0);
    check("sh_mem_lit", memArr[8], 32'hCAFE3344);

    doReq(0, 2'b00, 0, 32'h102, 0, 0, 0, 0);
    check("mis_lw_rdata", cpu_rdata, 32'd0);
    doReq(1, 2'b01, 0, 32'h101, 32'h1234, 0, 0, 0);
    doReq(0, 2'b11, 0, 32'h40, 0, 0, 0, 0);

    doReq(0, 2'b00, 0, 32'h14, 0, 5, 0, 0);
    doReq(1, 2'b10, 0, 32'h17, $urandom, 3, 5, 0);
    doReq(0, 2'b00, 0, 32'h18, 0, 0, 0, 1);
    doReq(1, 2'b01, 0, 32'h1A, $urandom, 0, 0, 1);
    doReq(1, 2'b00, 0, 32'h1C, $urandom, 0, 0, 1);

    // Reset while a write waits for ack.
    idle(1);
    cpu_req = 1; cpu_write = 1; cpu_width = 2'b00; cpu_addr = 32'h24; cpu_wdata = $urandom;
    noAck = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) expQ.push_back(mk(1, 1, 32'h24, cpu_wdata, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 reset = 1; cpu_req = 0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("midreset");
    @(posedge clk);
    #1 reset = 0; noAck = 0; inDoneCycle = 0;

    memArr[10] = 32'hA5A5_1234;
    doReq(0, 2'b01, 0, 32'h2A, 0, 0, 0, 0);
    check("b2b_lhu_lit", cpu_rdata, 32'h0000A5A5);
    doReq(1, 2'b00, 0, 32'h2C, 32'h0BAD_F00D, 0, 0, 0);
    check("b2b_sw_mem_lit", memArr[11], 32'h0BADF00D);

    for (int it = 0; it < 150; it++) begin
      rSel = $urandom_range(0, 9);
      rWidth = (rSel < 4) ? 2'b00 : (rSel < 7) ? 2'b01 : (rSel < 9) ? 2'b10 : 2'b11;
      rA = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        if (rWidth == 2'b00) rA[1:0] = 2'b00;
        if (rWidth == 2'b01) rA[0] = 1'b0;
      end
      rW = $urandom;
      doReq(1'($urandom), rWidth, 1'($urandom), rA, rW, $urandom_range(0, 5),
            $urandom_range(0, 5), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
